// File: rtl/arc4_pkg.sv
// arc4_pkg: shared state encoding, printable range and key-byte selection for the ARC4 encryptor
package arc4_pkg;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_KSA, S_LEN, S_PRGA, S_DONE, S_ABORT} state_t;
  localparam logic [7:0] PRINTABLE_LO = 8'h20;
  localparam logic [7:0] PRINTABLE_HI = 8'h7E;
  localparam int KEY_BYTES = 3;
  function automatic logic [7:0] keybyte(input logic [23:0] key, input logic [1:0] idx);
    return idx == 2'd0 ? key[23:16] : idx == 2'd1 ? key[15:8] : key[7:0];
  endfunction
endpackage

// File: rtl/arc4_encrypt_s_mem.sv
// s_mem: 256x8 single-port synchronous RAM holding the ARC4 state array
module s_mem (
  input  logic       clk,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wrdata,
  input  logic       i_wren,
  output logic [7:0] o_rddata
);
  logic [7:0] r_mem [256];
  always_ff @(posedge clk) begin
    if (i_wren) r_mem[i_addr] <= i_wrdata;
    o_rddata <= r_mem[i_addr];
  end
endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4-encrypts a length-prefixed plaintext buffer into a length-prefixed ciphertext buffer
module arc4_encrypt
  import arc4_pkg::*;
#(
  parameter bit CHECK_PRINTABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  output logic        err,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);
  state_t      r_state, w_next;
  logic [2:0]  r_ph;
  logic [7:0]  r_i, r_j, r_si, r_sj, r_len;
  logic [8:0]  r_k;
  logic [1:0]  r_kidx;
  logic [23:0] r_key;
  logic        r_err;
  logic [7:0]  w_s_addr, w_s_wdata, w_s_q, w_i_inc, w_j_ksa, w_j_prga;
  logic        w_s_wren, w_pt_ok, w_last, w_ph_wrap;

  s_mem u_s_mem (
    .clk      (clk),
    .i_addr   (w_s_addr),
    .i_wrdata (w_s_wdata),
    .i_wren   (w_s_wren),
    .o_rddata (w_s_q)
  );

  assign w_i_inc   = r_i + 8'd1;
  assign w_j_ksa   = r_j + w_s_q + keybyte(r_key, r_kidx);
  assign w_j_prga  = r_j + w_s_q;
  assign w_pt_ok   = !CHECK_PRINTABLE || (pt_rddata >= PRINTABLE_LO && pt_rddata <= PRINTABLE_HI);
  assign w_last    = r_k == {1'b0, r_len};
  // KSA steps take 4 phases, PRGA steps 6; the phase counter wraps within each step
  assign w_ph_wrap = (r_state == S_KSA && r_ph == 3'd3) || r_ph == 3'd5;

  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = en ? S_INIT : S_IDLE;
      S_INIT:  w_next = r_i == 8'hFF ? S_KSA : S_INIT;
      S_KSA:   w_next = (r_ph == 3'd3 && r_i == 8'hFF) ? S_LEN : S_KSA;
      S_LEN:   w_next = r_ph != 3'd1 ? S_LEN : pt_rddata == 8'd0 ? S_DONE : S_PRGA;
      S_PRGA:  w_next = r_ph != 3'd5 ? S_PRGA : !w_pt_ok ? S_ABORT : w_last ? S_DONE : S_PRGA;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_s_addr  = r_i;
    w_s_wdata = r_i;
    w_s_wren  = 1'b0;
    ct_addr   = 8'd0;
    ct_wrdata = 8'd0;
    ct_wren   = 1'b0;
    case (r_state)
      S_INIT: w_s_wren = 1'b1;
      S_KSA, S_PRGA: begin
        if (r_ph == 3'd0 && r_state == S_PRGA) w_s_addr = w_i_inc;
        if (r_ph == 3'd1) w_s_addr = r_state == S_KSA ? w_j_ksa : w_j_prga;
        if (r_ph == 3'd2) begin
          w_s_wdata = w_s_q;
          w_s_wren  = 1'b1;
        end
        if (r_ph == 3'd3) begin
          w_s_addr  = r_j;
          w_s_wdata = r_si;
          w_s_wren  = 1'b1;
        end
        if (r_ph == 3'd4) w_s_addr = r_si + r_sj;
        if (r_ph == 3'd5) begin
          ct_addr   = r_k[7:0];
          ct_wrdata = pt_rddata ^ w_s_q;
          ct_wren   = w_pt_ok;
        end
      end
      S_LEN: begin
        ct_wrdata = pt_rddata;
        ct_wren   = r_ph == 3'd1;
      end
      default: ;
    endcase
  end

  assign pt_addr = r_state == S_PRGA ? r_k[7:0] : 8'd0;
  assign rdy     = r_state == S_IDLE;
  assign err     = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph   <= 3'd0;
      r_err  <= 1'b0;
      r_i    <= 8'd0;
      r_j    <= 8'd0;
      r_si   <= 8'd0;
      r_sj   <= 8'd0;
      r_len  <= 8'd0;
      r_k    <= 9'd0;
      r_kidx <= 2'd0;
      r_key  <= 24'd0;
    end else begin
      r_ph <= (w_next != r_state || w_ph_wrap) ? 3'd0 : r_ph + 3'd1;
      case (r_state)
        S_IDLE: if (en) begin
          r_key  <= key;
          r_err  <= 1'b0;
          r_i    <= 8'd0;
          r_j    <= 8'd0;
          r_kidx <= 2'd0;
        end
        S_INIT: r_i <= w_i_inc;
        S_KSA: begin
          if (r_ph == 3'd1) begin
            r_si <= w_s_q;
            r_j  <= w_j_ksa;
          end
          if (r_ph == 3'd3) begin
            r_i    <= w_i_inc;
            r_kidx <= r_kidx == 2'(KEY_BYTES - 1) ? 2'd0 : r_kidx + 2'd1;
          end
        end
        S_LEN: begin
          r_len <= pt_rddata;
          r_i   <= 8'd0;
          r_j   <= 8'd0;
          r_k   <= 9'd1;
        end
        S_PRGA: begin
          if (r_ph == 3'd0) r_i <= w_i_inc;
          if (r_ph == 3'd1) begin
            r_si <= w_s_q;
            r_j  <= w_j_prga;
          end
          if (r_ph == 3'd2) r_sj <= w_s_q;
          if (r_ph == 3'd5) begin
            r_k   <= r_k + 9'd1;
            r_err <= !w_pt_ok;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
